// File: rtl/urng_pkg.sv
// Shared types and constants for the shared Tausworthe URNG controller.
package urng_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StRun
    } urng_state_e;

    // Seeds loaded on reset
    localparam logic [31:0] Seed0Rst = 32'haa0aa0aa;
    localparam logic [31:0] Seed1Rst = 32'hb00b00bb;
    localparam logic [31:0] Seed2Rst = 32'hd00b00dd;

    // Per-component masks drop the bits that would degenerate each LFSR
    localparam logic [31:0] Mask0 = 32'hfffffffe;
    localparam logic [31:0] Mask1 = 32'hfffffff8;
    localparam logic [31:0] Mask2 = 32'hfffffff0;

    // Shift triplets (a, b, c) per component
    localparam int unsigned Sh0A = 13;
    localparam int unsigned Sh0B = 19;
    localparam int unsigned Sh0C = 12;
    localparam int unsigned Sh1A = 2;
    localparam int unsigned Sh1B = 25;
    localparam int unsigned Sh1C = 4;
    localparam int unsigned Sh2A = 3;
    localparam int unsigned Sh2B = 11;
    localparam int unsigned Sh2C = 17;

    // Smallest legal seed per component
    localparam logic [31:0] SeedMin0 = 32'd2;
    localparam logic [31:0] SeedMin1 = 32'd8;
    localparam logic [31:0] SeedMin2 = 32'd16;

endpackage

// File: rtl/urng_taus_core.sv
// Three-component 32-bit Tausworthe generator state with seed load port.
// word_o is the combinational output of the current state.
module urng_taus_core
    import urng_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_en_i,
    input  logic [1:0]  load_sel_i,
    input  logic [31:0] load_data_i,
    input  logic        adv_en_i,
    output logic [31:0] word_o
);

    logic [31:0] s0_q, s1_q, s2_q;
    logic [31:0] s0_d, s1_d, s2_d;
    logic [31:0] b0, b1, b2;

    // Next state: seed load takes precedence over an advance
    always_comb begin
        b0   = ((s0_q << Sh0A) ^ s0_q) >> Sh0B;
        b1   = ((s1_q << Sh1A) ^ s1_q) >> Sh1B;
        b2   = ((s2_q << Sh2A) ^ s2_q) >> Sh2B;
        s0_d = s0_q;
        s1_d = s1_q;
        s2_d = s2_q;
        if (load_en_i) begin
            unique case (load_sel_i)
                2'd0:    s0_d = load_data_i;
                2'd1:    s1_d = load_data_i;
                2'd2:    s2_d = load_data_i;
                default: ;
            endcase
        end else if (adv_en_i) begin
            s0_d = ((s0_q & Mask0) << Sh0C) ^ b0;
            s1_d = ((s1_q & Mask1) << Sh1C) ^ b1;
            s2_d = ((s2_q & Mask2) << Sh2C) ^ b2;
        end
    end

    // Generator state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_q <= Seed0Rst;
            s1_q <= Seed1Rst;
            s2_q <= Seed2Rst;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign word_o = s0_q ^ s1_q ^ s2_q;

endmodule

// File: rtl/urng_share_ctrl.sv
// Sequencing and round-robin sharing controller for one Tausworthe URNG.
// Optional word counter enabled by defining URNG_SHARE_STATS_EN.
module urng_share_ctrl
    import urng_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned WARMUP_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               seed_wr_i,
    input  logic [1:0]         seed_sel_i,
    input  logic [31:0]        seed_data_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [31:0]        rand_data_o,
    output logic               rand_valid_o,
    output logic               ready_o,
    output logic               seed_err_o
`ifdef URNG_SHARE_STATS_EN
    ,
    input  logic               count_clr_i,
    output logic [31:0]        word_count_o
`endif
);

    localparam int unsigned PtrW       = $clog2(NUM_REQ);
    localparam logic [PtrW:0] NReq     = (PtrW + 1)'(NUM_REQ);
    localparam logic [PtrW-1:0] PtrRst = PtrW'(NUM_REQ - 1);
    localparam logic [15:0] WarmupInit = 16'(WARMUP_CYCLES);

    urng_state_e        state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [31:0]        rand_data_q, rand_data_d;
    logic               rand_valid_q, rand_valid_d;
    logic               ready_q, ready_d;
    logic               seed_err_q, seed_err_d;

    logic               load_en, adv_en;
    logic               seed_legal;
    logic [31:0]        word;

    logic [NUM_REQ-1:0] rot;
    logic [PtrW:0]      off, sum;
    logic               found;
    logic [PtrW-1:0]    win;

    urng_taus_core u_core (
        .clock       (clock),
        .reset       (reset),
        .load_en_i   (load_en),
        .load_sel_i  (seed_sel_i),
        .load_data_i (seed_data_i),
        .adv_en_i    (adv_en),
        .word_o      (word)
    );

    // Seed legality: each component needs a nonzero value in its unmasked bits
    always_comb begin
        seed_legal = 1'b0;
        unique case (seed_sel_i)
            2'd0:    seed_legal = (seed_data_i >= SeedMin0);
            2'd1:    seed_legal = (seed_data_i >= SeedMin1);
            2'd2:    seed_legal = (seed_data_i >= SeedMin2);
            default: seed_legal = 1'b0;
        endcase
    end

    // Round-robin pick: rotate requests so bit 0 is pointer+1, take first set bit
    always_comb begin
        rot   = NUM_REQ'({req_i, req_i} >> ({1'b0, ptr_q} + (PtrW + 1)'(1)));
        found = 1'b0;
        off   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = (PtrW + 1)'(j);
            end
        end
        sum = {1'b0, ptr_q} + (PtrW + 1)'(1) + off;
        if (sum >= NReq) begin
            sum = sum - NReq;
        end
        win = sum[PtrW-1:0];
    end

    // FSM next state, grant and generator control
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        gnt_d        = '0;
        rand_data_d  = rand_data_q;
        rand_valid_d = 1'b0;
        seed_err_d   = seed_err_q;
        load_en      = 1'b0;
        adv_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    seed_err_d = 1'b0;
                    cnt_d      = WarmupInit;
                    state_d    = (WARMUP_CYCLES == 0) ? StRun : StWarmup;
                end
                if (seed_wr_i) begin
                    if (seed_legal) begin
                        load_en = 1'b1;
                    end else begin
                        seed_err_d = 1'b1;
                    end
                end
            end
            StWarmup: begin
                if (seed_wr_i) begin
                    seed_err_d = 1'b1;
                end
                if (stop_i) begin
                    state_d = StIdle;
                end else begin
                    adv_en = 1'b1;
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (seed_wr_i) begin
                    seed_err_d = 1'b1;
                end
                if (stop_i) begin
                    state_d = StIdle;
                end else if (found) begin
                    gnt_d        = {{(NUM_REQ - 1){1'b0}}, 1'b1} << win;
                    rand_data_d  = word;
                    rand_valid_d = 1'b1;
                    adv_en       = 1'b1;
                    ptr_d        = win;
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StRun);
    end

    // Control and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ptr_q        <= PtrRst;
            gnt_q        <= '0;
            rand_data_q  <= '0;
            rand_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            seed_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            rand_data_q  <= rand_data_d;
            rand_valid_q <= rand_valid_d;
            ready_q      <= ready_d;
            seed_err_q   <= seed_err_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign rand_data_o  = rand_data_q;
    assign rand_valid_o = rand_valid_q;
    assign ready_o      = ready_q;
    assign seed_err_o   = seed_err_q;

`ifdef URNG_SHARE_STATS_EN
    logic [31:0] word_count_q, word_count_d;

    // Delivered-word counter, saturating; clear beats increment
    always_comb begin
        word_count_d = word_count_q;
        if (count_clr_i) begin
            word_count_d = '0;
        end else if (rand_valid_q && (word_count_q != 32'hffffffff)) begin
            word_count_d = word_count_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count_o = word_count_q;
`endif

endmodule

// File: tb/tb_urng_share_ctrl.sv
// Directed self-checking bench for urng_share_ctrl (two instances: no warm-up, 16 warm-up).
`timescale 1ns/1ps
module tb_urng_share_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        seed_wr = 1'b0;
    logic [1:0]  seed_sel = 2'd0;
    logic [31:0] seed_data = 32'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [3:0]  gnt;
    logic [31:0] rand_data;
    logic        rand_valid, ready, seed_err;

    logic        start_b = 1'b0;
    logic [3:0]  req_b = 4'd0;
    logic [3:0]  gnt_b;
    logic [31:0] rand_data_b;
    logic        rand_valid_b, ready_b, seed_err_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m0, m1, m2;

    always #5 clock = ~clock;

    urng_share_ctrl #(.NUM_REQ(4), .WARMUP_CYCLES(0)) dut (
        .clock        (clock),
        .reset        (reset),
        .seed_wr_i    (seed_wr),
        .seed_sel_i   (seed_sel),
        .seed_data_i  (seed_data),
        .start_i      (start),
        .stop_i       (stop),
        .req_i        (req),
        .gnt_o        (gnt),
        .rand_data_o  (rand_data),
        .rand_valid_o (rand_valid),
        .ready_o      (ready),
        .seed_err_o   (seed_err)
`ifdef URNG_SHARE_STATS_EN
        ,
        .count_clr_i  (1'b0),
        .word_count_o ()
`endif
    );

    urng_share_ctrl #(.NUM_REQ(4), .WARMUP_CYCLES(16)) dut_w (
        .clock        (clock),
        .reset        (reset),
        .seed_wr_i    (1'b0),
        .seed_sel_i   (2'd0),
        .seed_data_i  (32'd0),
        .start_i      (start_b),
        .stop_i       (1'b0),
        .req_i        (req_b),
        .gnt_o        (gnt_b),
        .rand_data_o  (rand_data_b),
        .rand_valid_o (rand_valid_b),
        .ready_o      (ready_b),
        .seed_err_o   (seed_err_b)
`ifdef URNG_SHARE_STATS_EN
        ,
        .count_clr_i  (1'b0),
        .word_count_o ()
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic m_reset();
        m0 = 32'haa0aa0aa;
        m1 = 32'hb00b00bb;
        m2 = 32'hd00b00dd;
    endtask

    function automatic logic [31:0] m_word();
        return m0 ^ m1 ^ m2;
    endfunction

    task automatic m_adv();
        logic [31:0] b;
        b  = ((m0 << 13) ^ m0) >> 19;
        m0 = ((m0 & 32'hfffffffe) << 12) ^ b;
        b  = ((m1 << 2) ^ m1) >> 25;
        m1 = ((m1 & 32'hfffffff8) << 4) ^ b;
        b  = ((m2 << 3) ^ m2) >> 11;
        m2 = ((m2 & 32'hfffffff0) << 17) ^ b;
    endtask

    initial begin
        logic [31:0] last;
        logic [3:0]  exp_g;
        int          n;

        m_reset();
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_gnt", {28'd0, gnt}, 32'd0);
        check_eq("rst_valid", {31'd0, rand_valid}, 32'd0);
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_err", {31'd0, seed_err}, 32'd0);
        check_eq("rst_data", rand_data, 32'd0);
        reset = 1'b0;

        // Start with no warm-up, single requester
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_ready", {31'd0, ready}, 32'd1);
        req = 4'b0001;
        tick();
        check_eq("first_gnt", {28'd0, gnt}, 32'd1);
        check_eq("first_data", rand_data, 32'hca0aa0cc);
        check_eq("first_valid", {31'd0, rand_valid}, 32'd1);
        m_adv();

        // All four requesting: rotate 1,2,3,0,...
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_g = 4'b0001 << ((k + 1) % 4);
            check_eq("rr_gnt", {28'd0, gnt}, {28'd0, exp_g});
            check_eq("rr_data", rand_data, m_word());
            last = m_word();
            m_adv();
        end
        req = 4'b0000;
        tick();
        check_eq("noreq_valid", {31'd0, rand_valid}, 32'd0);
        check_eq("noreq_gnt", {28'd0, gnt}, 32'd0);
        check_eq("noreq_hold", rand_data, last);

        // Stop together with a request: no grant, back to idle
        req  = 4'b0001;
        stop = 1'b1;
        tick();
        req  = 4'b0000;
        stop = 1'b0;
        check_eq("stop_gnt", {28'd0, gnt}, 32'd0);
        check_eq("stop_valid", {31'd0, rand_valid}, 32'd0);
        check_eq("stop_ready", {31'd0, ready}, 32'd0);

        // Illegal S1 seed in idle
        seed_wr   = 1'b1;
        seed_sel  = 2'd1;
        seed_data = 32'h00000005;
        tick();
        seed_wr = 1'b0;
        check_eq("bad_s1_err", {31'd0, seed_err}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_clr_err", {31'd0, seed_err}, 32'd0);
        check_eq("restart_ready", {31'd0, ready}, 32'd1);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        check_eq("resume_gnt", {28'd0, gnt}, 32'h4);
        check_eq("resume_data", rand_data, m_word());
        m_adv();

        // Seed write in run is rejected
        seed_wr   = 1'b1;
        seed_sel  = 2'd0;
        seed_data = 32'h12345678;
        tick();
        seed_wr = 1'b0;
        check_eq("run_wr_err", {31'd0, seed_err}, 32'd1);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        check_eq("run_wr_ignored", rand_data, m_word());
        m_adv();
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Legal S0 load, then start+stop together stays idle
        seed_wr = 1'b1;
        tick();
        seed_wr = 1'b0;
        m0 = 32'h12345678;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("startstop_ready", {31'd0, ready}, 32'd0);
        check_eq("startstop_err", {31'd0, seed_err}, 32'd1);
        tick();
        start = 1'b0;
        check_eq("start2_ready", {31'd0, ready}, 32'd1);
        req = 4'b0001;
        tick();
        check_eq("loaded_data", rand_data, m_word());
        m_adv();
        req = 4'b1111;
        tick();
        check_eq("burst_gnt", {28'd0, gnt}, 32'h2);

        // Reset in the middle of a burst
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_gnt", {28'd0, gnt}, 32'd0);
        check_eq("midrst_valid", {31'd0, rand_valid}, 32'd0);
        check_eq("midrst_ready", {31'd0, ready}, 32'd0);
        req = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        req = 4'b1111;
        tick();
        req = 4'b0000;
        check_eq("postrst_gnt", {28'd0, gnt}, 32'd1);
        check_eq("postrst_data", rand_data, 32'hca0aa0cc);

        // Warm-up instance: 16 discarded advances
        m_reset();
        for (int k = 0; k < 16; k++) m_adv();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!ready_b && n < 40) begin
            tick();
            n++;
        end
        check_eq("warmup_cycles", n, 32'd16);
        req_b = 4'b0001;
        tick();
        req_b = 4'b0000;
        check_eq("warmup_gnt", {28'd0, gnt_b}, 32'd1);
        check_eq("warmup_data", rand_data_b, m_word());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
